// File: rtl/cpu_pwr_seq_pkg.sv
// Shared types and helpers for the CPU cluster power sequencer.
// State encodings are mirrored in the PMU software headers; keep them stable.
package cpu_pwr_seq_pkg;

    // Encodings visible to software through pwr_status
    localparam logic [2:0] PWR_STATUS_OFF       = 3'd0;
    localparam logic [2:0] PWR_STATUS_WAIT_SLOT = 3'd1;
    localparam logic [2:0] PWR_STATUS_RAMP      = 3'd2;
    localparam logic [2:0] PWR_STATUS_RST_HOLD  = 3'd3;
    localparam logic [2:0] PWR_STATUS_ON        = 3'd4;
    localparam logic [2:0] PWR_STATUS_GATED     = 3'd5;
    localparam logic [2:0] PWR_STATUS_DRAIN     = 3'd6;
    localparam logic [2:0] PWR_STATUS_UNUSED    = 3'd7;

    typedef enum logic [2:0] {
        PWR_OFF       = PWR_STATUS_OFF,
        PWR_WAIT_SLOT = PWR_STATUS_WAIT_SLOT,
        PWR_RAMP      = PWR_STATUS_RAMP,
        PWR_RST_HOLD  = PWR_STATUS_RST_HOLD,
        PWR_ON        = PWR_STATUS_ON,
        PWR_GATED     = PWR_STATUS_GATED,
        PWR_DRAIN     = PWR_STATUS_DRAIN
    } pwr_state_e;

    typedef struct packed {
        logic pwr_en;
        logic iso;
        logic rst;
        logic clk_en;
    } pwr_ctrl_t;

    // Power-domain controls as a pure function of the state; unknown
    // encodings fall back to the fully isolated, held-in-reset values.
    function automatic pwr_ctrl_t pwr_decode(input pwr_state_e s);
        pwr_ctrl_t c;
        case (s)
            PWR_OFF:       c = '{pwr_en: 1'b0, iso: 1'b1, rst: 1'b1, clk_en: 1'b0};
            PWR_WAIT_SLOT: c = '{pwr_en: 1'b0, iso: 1'b1, rst: 1'b1, clk_en: 1'b0};
            PWR_RAMP:      c = '{pwr_en: 1'b1, iso: 1'b1, rst: 1'b1, clk_en: 1'b0};
            PWR_RST_HOLD:  c = '{pwr_en: 1'b1, iso: 1'b0, rst: 1'b1, clk_en: 1'b1};
            PWR_ON:        c = '{pwr_en: 1'b1, iso: 1'b0, rst: 1'b0, clk_en: 1'b1};
            PWR_GATED:     c = '{pwr_en: 1'b1, iso: 1'b0, rst: 1'b0, clk_en: 1'b0};
            PWR_DRAIN:     c = '{pwr_en: 1'b1, iso: 1'b1, rst: 1'b1, clk_en: 1'b0};
            default:       c = '{pwr_en: 1'b0, iso: 1'b1, rst: 1'b1, clk_en: 1'b0};
        endcase
        return c;
    endfunction

    // Core is powered and usable from the requester's point of view
    function automatic logic pwr_is_ack(input pwr_state_e s);
        return (s == PWR_ON) || (s == PWR_GATED);
    endfunction

    // Core is in a transitional state
    function automatic logic pwr_is_busy(input pwr_state_e s);
        return (s == PWR_WAIT_SLOT) || (s == PWR_RAMP) ||
               (s == PWR_RST_HOLD)  || (s == PWR_DRAIN);
    endfunction

endpackage

// File: rtl/cpu_pwr_seq_core.sv
// Per-core power sequencer: FSM plus phase counter and WFI idle counter.
module cpu_pwr_seq_core
    import cpu_pwr_seq_pkg::*;
#(
    parameter int RAMP_CYCLES      = 16,
    parameter int RST_HOLD_CYCLES  = 8,
    parameter int IDLE_GATE_CYCLES = 32,
    parameter int CNT_W            = 8
) (
    input  logic       clk_pclk,
    input  logic       rst_poreset,
    input  logic       i_req,
    input  logic       i_wfi,
    input  logic       i_wake,
    input  logic       i_grant,
    output pwr_state_e o_state,
    output logic       o_in_ramp,
    output logic       o_wait_slot
);

    localparam logic [CNT_W-1:0] RAMP_LAST = CNT_W'(RAMP_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] IDLE_MAX  = CNT_W'(IDLE_GATE_CYCLES);
    localparam bit               GATE_EN   = (IDLE_GATE_CYCLES != 0);

    pwr_state_e       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_idle;

    // Sequencer: phase counter times RAMP/RST_HOLD/DRAIN, idle counter times WFI in ON
    always_ff @(posedge clk_pclk) begin
        if (rst_poreset) begin
            r_state <= PWR_OFF;
            r_cnt   <= '0;
            r_idle  <= '0;
        end else begin
            case (r_state)
                PWR_OFF: begin
                    if (i_req) r_state <= PWR_WAIT_SLOT;
                end
                PWR_WAIT_SLOT: begin
                    if (!i_req) begin
                        r_state <= PWR_OFF;
                    end else if (i_grant) begin
                        r_state <= PWR_RAMP;
                        r_cnt   <= '0;
                    end
                end
                // Request drops are deliberately ignored until reset release completes
                PWR_RAMP: begin
                    if (r_cnt == RAMP_LAST) begin
                        r_state <= PWR_RST_HOLD;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                PWR_RST_HOLD: begin
                    if (r_cnt == HOLD_LAST) begin
                        r_cnt <= '0;
                        if (i_req) begin
                            r_state <= PWR_ON;
                            r_idle  <= '0;
                        end else begin
                            r_state <= PWR_DRAIN;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                PWR_ON: begin
                    if (!i_req) begin
                        r_state <= PWR_DRAIN;
                        r_cnt   <= '0;
                    end else if (GATE_EN && (r_idle == IDLE_MAX)) begin
                        r_state <= PWR_GATED;
                    end else if (i_wfi) begin
                        if (r_idle != IDLE_MAX) r_idle <= r_idle + 1'b1;
                    end else begin
                        r_idle <= '0;
                    end
                end
                // Power-down wins over wake
                PWR_GATED: begin
                    if (!i_req) begin
                        r_state <= PWR_DRAIN;
                        r_cnt   <= '0;
                    end else if (i_wake || !i_wfi) begin
                        r_state <= PWR_ON;
                        r_idle  <= '0;
                    end
                end
                PWR_DRAIN: begin
                    if (r_cnt == HOLD_LAST) begin
                        r_state <= PWR_OFF;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                // Corrupted encoding: take the safe path down
                default: begin
                    r_state <= PWR_DRAIN;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign o_state     = r_state;
    assign o_in_ramp   = (r_state == PWR_RAMP);
    assign o_wait_slot = (r_state == PWR_WAIT_SLOT);

endmodule

// File: rtl/cpu_cluster_pwr_seq.sv
// Cluster power sequencer: per-core sequencers plus inrush-limited
// round-robin grant of power-up slots.
module cpu_cluster_pwr_seq
    import cpu_pwr_seq_pkg::*;
#(
    parameter int NUM_CORES         = 8,
    parameter int RAMP_CYCLES       = 16,
    parameter int RST_HOLD_CYCLES   = 8,
    parameter int IDLE_GATE_CYCLES  = 32,
    parameter int MAX_CONCURRENT_UP = 2,
    parameter int CNT_W             = 8
) (
    input  logic                   clk_pclk,
    input  logic                   rst_poreset,
    input  logic [NUM_CORES-1:0]   pwr_req,
    output logic [NUM_CORES-1:0]   pwr_ack,
    input  logic [NUM_CORES-1:0]   core_wfi,
    input  logic [NUM_CORES-1:0]   core_wake,
    output logic [NUM_CORES-1:0]   core_pwr_en,
    output logic [NUM_CORES-1:0]   core_iso,
    output logic [NUM_CORES-1:0]   core_rst,
    output logic [NUM_CORES-1:0]   core_clk_en,
    output logic [NUM_CORES*3-1:0] pwr_status,
    output logic                   busy
);

    localparam int             PTR_W  = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam logic [4:0]     MAX_UP = 5'(MAX_CONCURRENT_UP);
    localparam logic [PTR_W:0] NC     = (PTR_W + 1)'(NUM_CORES);

    pwr_state_e           w_state [NUM_CORES];
    logic [NUM_CORES-1:0] w_in_ramp;
    logic [NUM_CORES-1:0] w_wait_slot;
    logic [NUM_CORES-1:0] w_grant;
    logic [NUM_CORES-1:0] w_busy;
    logic [4:0]           w_ramp_cnt;
    logic                 w_slot_free;
    logic                 w_found;
    logic [PTR_W-1:0]     w_gnt_idx;
    logic [PTR_W:0]       w_sum;
    logic [PTR_W-1:0]     w_idx;
    logic [PTR_W-1:0]     r_ptr;

    for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_core
        pwr_ctrl_t w_ctrl;

        cpu_pwr_seq_core #(
            .RAMP_CYCLES      (RAMP_CYCLES),
            .RST_HOLD_CYCLES  (RST_HOLD_CYCLES),
            .IDLE_GATE_CYCLES (IDLE_GATE_CYCLES),
            .CNT_W            (CNT_W)
        ) u_core (
            .clk_pclk    (clk_pclk),
            .rst_poreset (rst_poreset),
            .i_req       (pwr_req[gi]),
            .i_wfi       (core_wfi[gi]),
            .i_wake      (core_wake[gi]),
            .i_grant     (w_grant[gi]),
            .o_state     (w_state[gi]),
            .o_in_ramp   (w_in_ramp[gi]),
            .o_wait_slot (w_wait_slot[gi])
        );

        assign w_ctrl              = pwr_decode(w_state[gi]);
        assign core_pwr_en[gi]     = w_ctrl.pwr_en;
        assign core_iso[gi]        = w_ctrl.iso;
        assign core_rst[gi]        = w_ctrl.rst;
        assign core_clk_en[gi]     = w_ctrl.clk_en;
        assign pwr_ack[gi]         = pwr_is_ack(w_state[gi]);
        assign w_busy[gi]          = pwr_is_busy(w_state[gi]);
        assign pwr_status[3*gi+:3] = w_state[gi];
    end

    assign busy = |w_busy;

    // Count cores currently ramping (registered state only, so a core leaving
    // RAMP this cycle still occupies its slot)
    always_comb begin
        w_ramp_cnt = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            w_ramp_cnt = w_ramp_cnt + 5'(w_in_ramp[i]);
        end
    end

    assign w_slot_free = (w_ramp_cnt < MAX_UP);

    // Round-robin pick of one waiting core, scanning upward from the pointer
    always_comb begin
        w_grant   = '0;
        w_found   = 1'b0;
        w_gnt_idx = '0;
        w_sum     = '0;
        w_idx     = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            w_sum = {1'b0, r_ptr} + (PTR_W + 1)'(k);
            if (w_sum >= NC) w_sum = w_sum - NC;
            w_idx = w_sum[PTR_W-1:0];
            if (w_slot_free && !w_found && w_wait_slot[w_idx]) begin
                w_grant[w_idx] = 1'b1;
                w_found        = 1'b1;
                w_gnt_idx      = w_idx;
            end
        end
    end

    // Pointer moves past the last granted core
    always_ff @(posedge clk_pclk) begin
        if (rst_poreset) begin
            r_ptr <= '0;
        end else if (w_found) begin
            r_ptr <= (w_gnt_idx == PTR_W'(NUM_CORES - 1)) ? '0 : w_gnt_idx + 1'b1;
        end
    end

endmodule

// File: tb/tb_cpu_cluster_pwr_seq.sv
// Directed bench for the cluster power sequencer (defaults: 8 cores,
// ramp 16, hold 8, gate 32, 2 concurrent) plus a 1-core no-gating instance.
module tb_cpu_cluster_pwr_seq;

    localparam logic [2:0] S_OFF = 3'd0, S_WAIT = 3'd1, S_RAMP = 3'd2, S_HOLD = 3'd3,
                           S_ON = 3'd4, S_GATED = 3'd5, S_DRAIN = 3'd6;

    logic        clk_pclk = 1'b0;
    logic        rst_poreset;
    logic [7:0]  pwr_req, pwr_ack, core_wfi, core_wake;
    logic [7:0]  core_pwr_en, core_iso, core_rst, core_clk_en;
    logic [23:0] pwr_status;
    logic        busy;

    logic        ng_req, ng_ack, ng_wfi, ng_wake, ng_pwr_en, ng_iso, ng_rst, ng_clk_en, ng_busy;
    logic [2:0]  ng_status;

    int checks = 0;
    int errors = 0;

    always #5 clk_pclk = ~clk_pclk;

    cpu_cluster_pwr_seq dut (
        .clk_pclk    (clk_pclk),
        .rst_poreset (rst_poreset),
        .pwr_req     (pwr_req),
        .pwr_ack     (pwr_ack),
        .core_wfi    (core_wfi),
        .core_wake   (core_wake),
        .core_pwr_en (core_pwr_en),
        .core_iso    (core_iso),
        .core_rst    (core_rst),
        .core_clk_en (core_clk_en),
        .pwr_status  (pwr_status),
        .busy        (busy)
    );

    cpu_cluster_pwr_seq #(
        .NUM_CORES         (1),
        .IDLE_GATE_CYCLES  (0),
        .MAX_CONCURRENT_UP (1)
    ) dut_ng (
        .clk_pclk    (clk_pclk),
        .rst_poreset (rst_poreset),
        .pwr_req     (ng_req),
        .pwr_ack     (ng_ack),
        .core_wfi    (ng_wfi),
        .core_wake   (ng_wake),
        .core_pwr_en (ng_pwr_en),
        .core_iso    (ng_iso),
        .core_rst    (ng_rst),
        .core_clk_en (ng_clk_en),
        .pwr_status  (ng_status),
        .busy        (ng_busy)
    );

    function automatic logic [2:0] st(input int i);
        return pwr_status[3*i +: 3];
    endfunction

    // Expected core-0 state k cycles after pwr_req rises with a free slot
    function automatic logic [2:0] exp_up(input int k);
        if (k <= 0)  return S_OFF;
        if (k == 1)  return S_WAIT;
        if (k <= 17) return S_RAMP;
        if (k <= 25) return S_HOLD;
        return S_ON;
    endfunction

    task automatic step();
        @(posedge clk_pclk);
        #1;
    endtask

    task automatic apply_reset();
        rst_poreset = 1'b1;
        pwr_req = '0; core_wfi = '0; core_wake = '0;
        ng_req = 1'b0; ng_wfi = 1'b0; ng_wake = 1'b0;
        step();
        step();
        rst_poreset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (core_pwr_en !== 8'h00) begin errors++; $display("FAIL reset_pwr_en: got %h expected 00", core_pwr_en); end
        checks++; if (core_iso !== 8'hFF) begin errors++; $display("FAIL reset_iso: got %h expected ff", core_iso); end
        checks++; if (core_rst !== 8'hFF) begin errors++; $display("FAIL reset_rst: got %h expected ff", core_rst); end
        checks++; if (core_clk_en !== 8'h00) begin errors++; $display("FAIL reset_clk_en: got %h expected 00", core_clk_en); end
        checks++; if (pwr_ack !== 8'h00) begin errors++; $display("FAIL reset_ack: got %h expected 00", pwr_ack); end
        checks++; if (pwr_status !== 24'h0) begin errors++; $display("FAIL reset_status: got %h expected 000000", pwr_status); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    endtask

    task automatic test_single_up_down();
        apply_reset();
        pwr_req[0] = 1'b1;
        for (int k = 1; k <= 26; k++) begin
            step();
            checks++; if (st(0) !== exp_up(k)) begin errors++; $display("FAIL up_state k=%0d: got %0d expected %0d", k, st(0), exp_up(k)); end
            if (k == 1) begin checks++; if (core_pwr_en[0] !== 1'b0) begin errors++; $display("FAIL up_pwr_en_early: got %b expected 0", core_pwr_en[0]); end end
            if (k == 2) begin checks++; if (core_pwr_en[0] !== 1'b1) begin errors++; $display("FAIL up_pwr_en: got %b expected 1", core_pwr_en[0]); end end
            if (k == 17) begin checks++; if (core_iso[0] !== 1'b1) begin errors++; $display("FAIL up_iso_early: got %b expected 1", core_iso[0]); end end
            if (k == 18) begin checks++; if ({core_iso[0], core_rst[0]} !== 2'b01) begin errors++; $display("FAIL up_iso_release: got %b expected 01", {core_iso[0], core_rst[0]}); end end
            if (k == 25) begin checks++; if (pwr_ack[0] !== 1'b0) begin errors++; $display("FAIL up_ack_early: got %b expected 0", pwr_ack[0]); end end
            if (k == 26) begin checks++; if ({pwr_ack[0], core_rst[0], core_clk_en[0]} !== 3'b101) begin errors++; $display("FAIL up_on: got %b expected 101", {pwr_ack[0], core_rst[0], core_clk_en[0]}); end end
        end
        repeat (4) step();
        pwr_req[0] = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            step();
            checks++; if (st(0) !== ((k < 9) ? S_DRAIN : S_OFF)) begin errors++; $display("FAIL down_state k=%0d: got %0d expected %0d", k, st(0), (k < 9) ? S_DRAIN : S_OFF); end
            if (k == 1) begin checks++; if ({pwr_ack[0], busy} !== 2'b01) begin errors++; $display("FAIL down_ack_busy: got %b expected 01", {pwr_ack[0], busy}); end end
            if (k == 9) begin checks++; if ({busy, core_pwr_en[0], core_iso[0]} !== 3'b001) begin errors++; $display("FAIL down_off: got %b expected 001", {busy, core_pwr_en[0], core_iso[0]}); end end
        end
    endtask

    task automatic test_inrush();
        int entry [8];
        int exp_entry [8];
        logic [2:0] prev [8];
        int n_ramp;
        exp_entry = '{2, 3, 19, 20, 36, 37, 53, 54};
        for (int i = 0; i < 8; i++) begin entry[i] = -1; prev[i] = S_OFF; end
        apply_reset();
        pwr_req = 8'hFF;
        for (int k = 1; k <= 85; k++) begin
            step();
            n_ramp = 0;
            for (int i = 0; i < 8; i++) begin
                if (st(i) == S_RAMP) n_ramp++;
                if (st(i) == S_RAMP && prev[i] != S_RAMP && entry[i] < 0) entry[i] = k;
                prev[i] = st(i);
            end
            checks++; if (n_ramp > 2) begin errors++; $display("FAIL inrush_limit k=%0d: got %0d ramping expected at most 2", k, n_ramp); end
        end
        for (int i = 0; i < 8; i++) begin
            checks++; if (entry[i] != exp_entry[i]) begin errors++; $display("FAIL inrush_order core%0d: got cycle %0d expected %0d", i, entry[i], exp_entry[i]); end
        end
        checks++; if (pwr_ack !== 8'hFF) begin errors++; $display("FAIL inrush_all_ack: got %h expected ff", pwr_ack); end
        pwr_req = 8'h00;
        repeat (10) step();
        checks++; if ({pwr_status, busy} !== 25'h0) begin errors++; $display("FAIL inrush_all_off: got %h/%b expected 0/0", pwr_status, busy); end
    endtask

    task automatic test_wfi_gating();
        apply_reset();
        pwr_req[0] = 1'b1;
        ng_req = 1'b1;
        repeat (26) step();
        checks++; if ({st(0), ng_status} !== {S_ON, S_ON}) begin errors++; $display("FAIL gate_setup: got %0d/%0d expected 4/4", st(0), ng_status); end
        core_wfi[0] = 1'b1;
        ng_wfi = 1'b1;
        for (int k = 1; k <= 33; k++) begin
            step();
            checks++; if (ng_clk_en !== 1'b1) begin errors++; $display("FAIL nogate_clk k=%0d: got %b expected 1", k, ng_clk_en); end
            if (k == 32) begin checks++; if ({st(0), core_clk_en[0]} !== {S_ON, 1'b1}) begin errors++; $display("FAIL gate_early: got %0d/%b expected 4/1", st(0), core_clk_en[0]); end end
            if (k == 33) begin checks++; if ({st(0), core_clk_en[0], pwr_ack[0]} !== {S_GATED, 1'b0, 1'b1}) begin errors++; $display("FAIL gate_enter: got %0d/%b/%b expected 5/0/1", st(0), core_clk_en[0], pwr_ack[0]); end end
        end
        core_wake[0] = 1'b1;
        step();
        core_wake[0] = 1'b0;
        checks++; if ({st(0), core_clk_en[0]} !== {S_ON, 1'b1}) begin errors++; $display("FAIL gate_wake: got %0d/%b expected 4/1", st(0), core_clk_en[0]); end
        for (int k = 1; k <= 33; k++) begin
            step();
            checks++; if (ng_clk_en !== 1'b1) begin errors++; $display("FAIL nogate_clk2 k=%0d: got %b expected 1", k, ng_clk_en); end
            if (k == 32) begin checks++; if (core_clk_en[0] !== 1'b1) begin errors++; $display("FAIL regate_early: got %b expected 1", core_clk_en[0]); end end
            if (k == 33) begin checks++; if (st(0) !== S_GATED) begin errors++; $display("FAIL regate: got %0d expected 5", st(0)); end end
        end
        core_wfi[0] = 1'b0;
        step();
        checks++; if ({st(0), core_clk_en[0]} !== {S_ON, 1'b1}) begin errors++; $display("FAIL gate_wfi_exit: got %0d/%b expected 4/1", st(0), core_clk_en[0]); end
        checks++; if (ng_status !== S_ON) begin errors++; $display("FAIL nogate_state: got %0d expected 4", ng_status); end
    endtask

    task automatic test_priority();
        apply_reset();
        pwr_req[0] = 1'b1;
        repeat (26) step();
        core_wfi[0] = 1'b1;
        repeat (33) step();
        checks++; if (st(0) !== S_GATED) begin errors++; $display("FAIL prio_setup: got %0d expected 5", st(0)); end
        pwr_req[0] = 1'b0;
        core_wake[0] = 1'b1;
        step();
        core_wake[0] = 1'b0;
        core_wfi[0] = 1'b0;
        checks++; if ({st(0), core_clk_en[0], pwr_ack[0]} !== {S_DRAIN, 1'b0, 1'b0}) begin errors++; $display("FAIL prio_drain: got %0d/%b/%b expected 6/0/0", st(0), core_clk_en[0], pwr_ack[0]); end
        repeat (8) step();
        checks++; if (st(0) !== S_OFF) begin errors++; $display("FAIL prio_off: got %0d expected 0", st(0)); end
    endtask

    task automatic test_drop_in_ramp();
        logic [2:0] e;
        apply_reset();
        pwr_req[0] = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (k <= 25)      e = exp_up(k);
            else if (k <= 33) e = S_DRAIN;
            else              e = S_OFF;
            checks++; if (st(0) !== e) begin errors++; $display("FAIL drop_ramp_state k=%0d: got %0d expected %0d", k, st(0), e); end
            checks++; if (pwr_ack[0] !== 1'b0) begin errors++; $display("FAIL drop_ramp_ack k=%0d: got %b expected 0", k, pwr_ack[0]); end
            if (k == 3) pwr_req[0] = 1'b0;
        end
    endtask

    task automatic test_drop_in_wait();
        apply_reset();
        pwr_req = 8'h07;
        for (int k = 1; k <= 30; k++) begin
            step();
            checks++; if (core_pwr_en[2] !== 1'b0) begin errors++; $display("FAIL drop_wait_pwr_en k=%0d: got %b expected 0", k, core_pwr_en[2]); end
            if (k == 3) begin checks++; if ({st(0), st(1)} !== {S_RAMP, S_RAMP}) begin errors++; $display("FAIL drop_wait_slots: got %0d/%0d expected 2/2", st(0), st(1)); end end
            if (k == 5) begin
                checks++; if (st(2) !== S_WAIT) begin errors++; $display("FAIL drop_wait_waiting: got %0d expected 1", st(2)); end
                pwr_req[2] = 1'b0;
            end
            if (k == 6) begin checks++; if (st(2) !== S_OFF) begin errors++; $display("FAIL drop_wait_off: got %0d expected 0", st(2)); end end
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        pwr_req = 8'h09;
        repeat (28) step();
        checks++; if ({st(0), st(3)} !== {S_ON, S_ON}) begin errors++; $display("FAIL rmid_setup_on: got %0d/%0d expected 4/4", st(0), st(3)); end
        pwr_req = 8'h0E;
        repeat (3) step();
        checks++; if ({st(0), st(1), st(2), st(3)} !== {S_DRAIN, S_RAMP, S_RAMP, S_ON}) begin errors++; $display("FAIL rmid_setup_mix: got %0d%0d%0d%0d expected 6224", st(0), st(1), st(2), st(3)); end
        rst_poreset = 1'b1;
        step();
        checks++; if ({core_pwr_en, core_iso, core_rst, core_clk_en, pwr_ack} !== 40'h00_FF_FF_00_00) begin errors++; $display("FAIL rmid_outputs: got %h expected 00ffff0000", {core_pwr_en, core_iso, core_rst, core_clk_en, pwr_ack}); end
        checks++; if ({pwr_status, busy} !== 25'h0) begin errors++; $display("FAIL rmid_status_busy: got %h/%b expected 0/0", pwr_status, busy); end
        rst_poreset = 1'b0;
        step();
        checks++; if ({st(1), st(2), st(3)} !== {S_WAIT, S_WAIT, S_WAIT}) begin errors++; $display("FAIL rmid_wait: got %0d%0d%0d expected 111", st(1), st(2), st(3)); end
        step();
        checks++; if ({st(1), st(2), st(3)} !== {S_RAMP, S_WAIT, S_WAIT}) begin errors++; $display("FAIL rmid_rr_restart: got %0d%0d%0d expected 211", st(1), st(2), st(3)); end
    endtask

    initial begin
        rst_poreset = 1'b1;
        pwr_req = '0; core_wfi = '0; core_wake = '0;
        ng_req = 1'b0; ng_wfi = 1'b0; ng_wake = 1'b0;
        test_reset();
        test_single_up_down();
        test_inrush();
        test_wfi_gating();
        test_priority();
        test_drop_in_ramp();
        test_drop_in_wait();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
